// File: rtl/fetch_pc_unit.sv
// Front end of the LEGv8 multicycle core: PC, instruction register and status register,
// with a req/ready instruction fetch that stalls the control unit while a fetch is outstanding.
module fetch_pc_unit #(
  parameter logic [63:0] PC_RESET = 64'h0000000000000000,
  parameter int          ADDR_W   = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        PS,
  input  logic              IL,
  input  logic              SL,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [ADDR_W-1:0] constant,
  input  logic [4:0]        status_in,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       instruction,
  output logic [4:0]        status,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              fetch_stall
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   fetch_addr_q, fetch_addr_d;
  logic [31:0]         ir_q, ir_d;
  logic [4:0]          status_q, status_d;
  logic                ir_load;

  // Branch offset arrives in words; scale to bytes as a signed quantity, wrap modulo 2^64.
  function automatic logic [ADDR_W-1:0] next_pc(
    input logic [ADDR_W-1:0] cur,
    input logic [1:0]        sel,
    input logic [ADDR_W-1:0] reg_val,
    input logic [ADDR_W-1:0] offset_words
  );
    logic signed [ADDR_W-1:0] offset_bytes;
    offset_bytes = $signed(offset_words) <<< 2;
    case (sel)
      2'b01:   next_pc = cur + {{(ADDR_W-3){1'b0}}, 3'd4};
      2'b10:   next_pc = reg_val;
      2'b11:   next_pc = cur + $unsigned(offset_bytes);
      default: next_pc = cur;
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pc_q         <= PC_RESET;
      ir_q         <= 32'h0;
      status_q     <= 5'h0;
      fetch_addr_q <= PC_RESET;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      status_q     <= status_d;
      fetch_addr_q <= fetch_addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (IL && !imem_ready) state_d = S_WAIT;
      S_WAIT:  if (imem_ready)        state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Reset masks the handshake outputs so nothing is requested while reset is held.
  always_comb begin
    imem_req    = 1'b0;
    imem_addr   = pc_q;
    fetch_stall = 1'b0;
    ir_load     = 1'b0;
    case (state_q)
      S_IDLE: begin
        imem_req    = IL & ~reset;
        imem_addr   = pc_q;
        fetch_stall = IL & ~imem_ready & ~reset;
        ir_load     = IL & imem_ready;
      end
      S_WAIT: begin
        imem_req    = ~reset;
        imem_addr   = fetch_addr_q;
        fetch_stall = ~imem_ready & ~reset;
        ir_load     = imem_ready;
      end
      default: ;
    endcase
  end

  always_comb begin
    pc_d         = pc_q;
    status_d     = status_q;
    ir_d         = ir_q;
    fetch_addr_d = fetch_addr_q;
    if (ir_load) ir_d = imem_rdata;
    if (state_q == S_IDLE && IL && !imem_ready) fetch_addr_d = pc_q;
    if (!fetch_stall) begin
      pc_d = next_pc(pc_q, PS, pc_in, constant);
      if (SL) status_d = status_in;
    end
  end

  assign pc          = pc_q;
  assign pc_plus4    = pc_q + {{(ADDR_W-3){1'b0}}, 3'd4};
  assign instruction = ir_q;
  assign status      = status_q;

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Front end of the LEGv8 multicycle core, directly upstream of the control unit.
- Owns the program counter (PC), the instruction register (IR) and the 5-bit status register.
- Fetches instruction words from instruction memory over a req/ready handshake and presents the IR to the control unit.
- Applies the control unit's PS, IL and SL fields, plus the generated constant, to update PC, IR and status.
- Asserts a stall while a fetch is outstanding. The control unit uses the stall as the inverted load-enable of its state register, so the control word is held.

Parameters:
- PC_RESET, 64'h0000000000000000, PC value after reset.
- ADDR_W, 64, PC and instruction address width. Must stay 64; it is a parameter for bench readability only.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- PS  input  2  PC function select from control word
- IL  input  1  instruction load request from control word
- SL  input  1  status load from control word
- pc_in  input  64  register operand (A bus) for BR/BLR/RET
- constant  input  64  constant generator output (branch offset, in words)
- status_in  input  5  ALU flags {V,C,N,Z,Zr} for status load
- imem_ready  input  1  instruction memory data valid
- imem_rdata  input  32  instruction memory read data
- imem_req  output  1  fetch request
- imem_addr  output  64  fetch address
- instruction  output  32  IR contents
- status  output  5  status register contents
- pc  output  64  current PC
- pc_plus4  output  64  PC+4, combinational, used as BL link value
- fetch_stall  output  1  fetch outstanding; PC and status updates are suppressed

Behaviour:
Reset (synchronous, checked at the clock edge):
- pc=PC_RESET, instruction=32'h0, status=5'h0, FSM=IDLE.
- imem_req=0 and fetch_stall=0 from the first edge with reset high.
- Reset overrides every other input.

FSM states: IDLE and WAIT.

IDLE:
- imem_req = IL; imem_addr = pc (combinational).
- If IL and imem_ready in the same cycle (zero-wait memory): IR<=imem_rdata at the edge, stay IDLE, fetch_stall=0.
- If IL and not imem_ready: latch fetch_addr<=pc, go to WAIT, fetch_stall=1 combinationally in this cycle.
- If not IL: imem_req=0. imem_ready is ignored and the IR is unchanged.

WAIT:
- imem_req=1 and imem_addr=fetch_addr (registered), held stable until ready.
- fetch_stall = ~imem_ready.
- On imem_ready: IR<=imem_rdata and go to IDLE. fetch_stall is 0 in that completing cycle, so the held control word's PS/SL take effect at the same edge.
- IL is ignored while in WAIT; there are no nested fetches.

PC update (only at an edge where fetch_stall=0):
- PS=00: PC held.
- PS=01: PC<=PC+4.
- PS=10: PC<=pc_in.
- PS=11: PC<=PC+(constant<<2).
- All arithmetic is 64-bit modulo 2^64; wrap-around is silent and there is no alignment check.
- When IL and PS!=00 occur in the same cycle, the fetch uses the pre-update PC.

Status register:
- status<=status_in when SL=1 and fetch_stall=0; otherwise held.

pc_plus4:
- Always equals pc+4, combinational, and wraps modulo 2^64.

Reset during WAIT:
- The fetch is abandoned and imem_req is 0 after the edge.
- A late imem_ready arriving in IDLE without IL is ignored.

Test Plan:
- Zero-wait fetch: reset, then IL=1, PS=01, imem_ready=1, imem_rdata=32'h8B020020 -> after one edge instruction=32'h8B020020, pc=4, imem_addr was 0, fetch_stall never high.
- Two-wait fetch: IL=1, PS=01, ready low for 2 cycles then high with data 32'hB4000040 -> imem_req high for 3 cycles, imem_addr=0 throughout, fetch_stall high for 2 cycles, pc stays 0 until the completing edge, then pc=4 and IR loaded.
- PS modes: pc=64'h100 -> PS=10 with pc_in=64'h2000 gives pc=64'h2000. PS=11 with constant=64'hFFFFFFFFFFFFFFFE gives pc=64'h1FF8. PS=00 holds the PC.
- Wrap-around: pc=64'hFFFFFFFFFFFFFFFC, PS=01 -> pc=0, and pc_plus4=0 before the edge.
- Status gating: SL=1, status_in=5'b10101 during a stalled WAIT cycle -> status unchanged; on the completing cycle -> status=5'b10101.
- Reset mid-fetch: enter WAIT, assert reset for one edge, then imem_ready=1 with IL=0 -> imem_req=0, instruction=0, pc=PC_RESET, FSM in IDLE.
